// File: rtl/vending_machine_param.sv
// vending_machine_param: parametrised coin-accepting vending controller.
// Credit is kept in nickel units; change and refunds are paid out as a train
// of one-nickel pulses on `change`. All outputs are registered.
// Optional feature macro: VEND_DOLLAR_EN adds a `dollar` coin input
// (20 nickels); requires CREDIT_W >= 5.
module vending_machine_param #(
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
`ifdef VEND_DOLLAR_EN
    input  logic                dollar,
`endif
    input  logic                cancel,
    output logic                dispense,
    output logic                change,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic {
        IDLE,
        CHANGE
    } state_t;

    // One extra bit so credit+coin can be compared against the credit ceiling
    localparam int SW = CREDIT_W + 1;
    localparam logic [SW-1:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [SW-1:0] PRICE_W    = SW'(PRICE);

`ifdef VEND_DOLLAR_EN
    localparam int NCOIN = 4;
`else
    localparam int NCOIN = 3;
`endif

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic                dispense_n, change_n, reject_n, busy_n;

    logic [NCOIN-1:0]    coins;
    logic                coin_any, coin_multi;
    logic [SW-1:0]       coin_val;
    logic [SW-1:0]       sum;
    logic                sum_ovf, sum_vend, sum_over;

    // Coin decode: one-hot check, coin value and candidate new credit
    always_comb begin
`ifdef VEND_DOLLAR_EN
        coins = {dollar, quarter, dime, nickel};
`else
        coins = {quarter, dime, nickel};
`endif
        coin_any   = |coins;
        coin_multi = ($countones(coins) > 1);
        coin_val   = '0;
        if (nickel)  coin_val = SW'(1);
        if (dime)    coin_val = SW'(2);
        if (quarter) coin_val = SW'(5);
`ifdef VEND_DOLLAR_EN
        if (dollar)  coin_val = SW'(20);
`endif
        sum      = {1'b0, credit} + coin_val;
        sum_ovf  = (sum > MAX_CREDIT);
        sum_vend = (sum >= PRICE_W);
        sum_over = (sum > PRICE_W);
    end

    // State, credit and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            credit      <= '0;
            dispense    <= 1'b0;
            change      <= 1'b0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            dispense    <= dispense_n;
            change      <= change_n;
            coin_reject <= reject_n;
            busy        <= busy_n;
        end
    end

    // Next-state and next-credit logic
    always_comb begin
        state_n  = state;
        credit_n = credit;
        case (state)
            IDLE: begin
                if (cancel) begin
                    if (credit != '0) state_n = CHANGE;
                end else if (coin_any && !coin_multi && !sum_ovf) begin
                    if (sum_vend) begin
                        credit_n = CREDIT_W'(sum - PRICE_W);
                        state_n  = sum_over ? CHANGE : IDLE;
                    end else begin
                        credit_n = sum[CREDIT_W-1:0];
                    end
                end
            end
            CHANGE: begin
                // Leave on the edge that pays the last nickel; a zero credit
                // here would be unreachable but simply returns to IDLE.
                if (credit != '0) credit_n = credit - CREDIT_W'(1);
                if (credit <= CREDIT_W'(1)) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Next values of the registered output pulses
    always_comb begin
        dispense_n = 1'b0;
        change_n   = 1'b0;
        reject_n   = 1'b0;
        busy_n     = 1'b0;
        case (state)
            IDLE: begin
                if (coin_any) begin
                    if (cancel || coin_multi || sum_ovf) reject_n = 1'b1;
                    else if (sum_vend)                   dispense_n = 1'b1;
                end
            end
            CHANGE: begin
                if (credit != '0) begin
                    change_n = 1'b1;
                    busy_n   = 1'b1;
                end
                if (coin_any) reject_n = 1'b1;
            end
            default: begin
                reject_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed self-checking bench for vending_machine_param.
// Main instance uses defaults (PRICE=3, CREDIT_W=6); a second instance uses
// PRICE=63 to reach the credit ceiling. VEND_DOLLAR_EN enables dollar steps.
module tb_vending_machine_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       nickel, dime, quarter, cancel;
    logic       dispense, change, coin_reject, busy;
    logic [5:0] credit;

    logic       n2, d2, q2, c2;
    logic       dispense2, change2, reject2, busy2;
    logic [5:0] credit2;

`ifdef VEND_DOLLAR_EN
    logic       dollar, dollar2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vending_machine_param #(.PRICE(3), .CREDIT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .nickel(nickel), .dime(dime), .quarter(quarter),
`ifdef VEND_DOLLAR_EN
        .dollar(dollar),
`endif
        .cancel(cancel),
        .dispense(dispense), .change(change), .coin_reject(coin_reject),
        .busy(busy), .credit(credit)
    );

    vending_machine_param #(.PRICE(63), .CREDIT_W(6)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .nickel(n2), .dime(d2), .quarter(q2),
`ifdef VEND_DOLLAR_EN
        .dollar(dollar2),
`endif
        .cancel(c2),
        .dispense(dispense2), .change(change2), .coin_reject(reject2),
        .busy(busy2), .credit(credit2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs to the main instance, then release them
    task automatic drive(input logic n, input logic d, input logic q, input logic c);
        nickel = n; dime = d; quarter = q; cancel = c;
        tick();
        nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0;
    endtask

    // Observe n cycles of idle inputs; change pattern bit i = cycle i
    task automatic cap(input int n, output int pat, output int nbusy,
                       output int ndisp, output int nrej);
        pat = 0; nbusy = 0; ndisp = 0; nrej = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (change)      pat = pat | (1 << i);
            if (busy)        nbusy++;
            if (dispense)    ndisp++;
            if (coin_reject) nrej++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pat, nb, nd, nr;
        rst_n = 1'b0;
        nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0;
        n2 = 1'b0; d2 = 1'b0; q2 = 1'b0; c2 = 1'b0;
`ifdef VEND_DOLLAR_EN
        dollar = 1'b0; dollar2 = 1'b0;
`endif
        #10 rst_n = 1'b1;
        #1;
        check("rst_credit", credit, 0);
        check("rst_dispense", dispense, 0);
        check("rst_change", change, 0);
        check("rst_reject", coin_reject, 0);
        check("rst_busy", busy, 0);

        // 1: nickel then dime -> exact price, no change
        drive(1, 0, 0, 0);
        check("t1_credit_n", credit, 1);
        check("t1_nodisp_n", dispense, 0);
        drive(0, 1, 0, 0);
        check("t1_dispense", dispense, 1);
        check("t1_credit", credit, 0);
        check("t1_nochg", change, 0);
        cap(4, pat, nb, nd, nr);
        check("t1_chg_after", pat, 0);
        check("t1_disp_after", nd, 0);

        // 2: dime then quarter -> vend, 4 change pulses
        drive(0, 1, 0, 0);
        check("t2_credit_d", credit, 2);
        drive(0, 0, 1, 0);
        check("t2_dispense", dispense, 1);
        check("t2_credit4", credit, 4);
        check("t2_chg0", change, 0);
        check("t2_busy0", busy, 0);
        cap(6, pat, nb, nd, nr);
        check("t2_chg_pattern", pat, 15);
        check("t2_busy_cycles", nb, 4);
        check("t2_no_disp", nd, 0);
        check("t2_credit_end", credit, 0);

        // 3: refund one nickel, then cancel with no credit
        drive(1, 0, 0, 0);
        check("t3_credit1", credit, 1);
        drive(0, 0, 0, 1);
        check("t3_cancel_chg", change, 0);
        check("t3_cancel_disp", dispense, 0);
        check("t3_cancel_credit", credit, 1);
        cap(4, pat, nb, nd, nr);
        check("t3_refund_pattern", pat, 1);
        check("t3_refund_disp", nd, 0);
        check("t3_refund_credit", credit, 0);
        drive(0, 0, 0, 1);
        cap(3, pat, nb, nd, nr);
        check("t3_idle_cancel", pat + nb + nd + nr + change + busy, 0);

        // 4: rejects
        drive(1, 1, 0, 0);
        check("t4_multi_rej", coin_reject, 1);
        check("t4_multi_credit", credit, 0);
        tick();
        check("t4_rej_clear", coin_reject, 0);
        drive(1, 0, 0, 1);
        check("t4_cancel_coin_rej", coin_reject, 1);
        check("t4_cancel_coin_credit", credit, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 0);
        check("t4_vend", dispense, 1);
        drive(0, 0, 1, 0);
        check("t4_change_rej", coin_reject, 1);
        check("t4_change_first", change, 1);
        check("t4_change_credit", credit, 3);
        cap(5, pat, nb, nd, nr);
        check("t4_change_rest", pat, 7);
        check("t4_no_more_rej", nr, 0);
        check("t4_credit_end", credit, 0);

        // 5a: PRICE=63 instance, ceiling and overflow
        for (int i = 0; i < 12; i++) begin
            q2 = 1'b1; tick(); q2 = 1'b0;
        end
        check("t5_credit60", credit2, 60);
        q2 = 1'b1; tick(); q2 = 1'b0;
        check("t5_ovf_rej", reject2, 1);
        check("t5_ovf_credit", credit2, 60);
        n2 = 1'b1; tick(); tick(); n2 = 1'b0;
        check("t5_credit62", credit2, 62);
        d2 = 1'b1; tick(); d2 = 1'b0;
        check("t5_ovf64_rej", reject2, 1);
        check("t5_ovf64_credit", credit2, 62);
        n2 = 1'b1; tick(); n2 = 1'b0;
        check("t5_max_vend", dispense2, 1);
        check("t5_max_credit", credit2, 0);
        tick();
        check("t5_max_nochg", change2 + busy2 + dispense2, 0);

        // 5b: reset mid-payout
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 0);
        tick();
        check("t5_paying", change, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_change", change, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_credit", credit, 0);
        check("t5_rst_disp", dispense, 0);
        #3 rst_n = 1'b1;
        tick();
        check("t5_post_rst_idle", change + busy + credit, 0);
        drive(1, 0, 0, 0);
        check("t5_post_rst_credit", credit, 1);
        drive(0, 0, 0, 1);
        cap(3, pat, nb, nd, nr);
        check("t5_post_rst_refund", pat, 1);

`ifdef VEND_DOLLAR_EN
        // 6: dollar -> vend and 17 change pulses
        dollar = 1'b1; tick(); dollar = 1'b0;
        check("t6_dispense", dispense, 1);
        check("t6_credit17", credit, 17);
        cap(20, pat, nb, nd, nr);
        check("t6_chg_pattern", pat, 32'h1FFFF);
        check("t6_busy", nb, 17);
        check("t6_credit_end", credit, 0);
        dollar = 1'b1; nickel = 1'b1; tick(); dollar = 1'b0; nickel = 1'b0;
        check("t6_multi_rej", coin_reject, 1);
        check("t6_multi_credit", credit, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
